// File: rtl/alu_arbiter_if.sv
// Bundle of requester-side and engine-side signals around the shared ALU arbiter.
// The arbiter uses the slave view; requesters and the engine sit on the master view.
interface alu_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DW   = 4,
  parameter int OPW  = 3
);
  logic [NREQ-1:0]     req;
  logic [NREQ*DW-1:0]  req_a;
  logic [NREQ*DW-1:0]  req_b;
  logic [NREQ*OPW-1:0] req_op;
  logic [NREQ-1:0]     gnt;
  logic [NREQ-1:0]     rsp_valid;
  logic [DW-1:0]       rsp_result;
  logic                rsp_err;
  logic                alu_start;
  logic [DW-1:0]       alu_a;
  logic [DW-1:0]       alu_b;
  logic [OPW-1:0]      alu_opcode;
  logic [DW-1:0]       alu_result;
  logic                alu_done;

  modport slave (
    input  req, req_a, req_b, req_op, alu_result, alu_done,
    output gnt, rsp_valid, rsp_result, rsp_err, alu_start, alu_a, alu_b, alu_opcode
  );

  modport master (
    output req, req_a, req_b, req_op, alu_result, alu_done,
    input  gnt, rsp_valid, rsp_result, rsp_err, alu_start, alu_a, alu_b, alu_opcode
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one ALU engine among NREQ requesters.
//
// state | meaning
// IDLE  | waiting for any request; winner operands latched on exit
// ISSUE | gnt and alu_start pulse for the winner, timeout counter cleared
// WAIT  | waiting for alu_done or timeout
// RESP  | rsp_valid pulse to the winner, round-robin pointer updated
//
// All outputs are registered: the *_n values computed for a transition are
// the values visible during the state being entered.
module alu_arbiter #(
  parameter int NREQ    = 4,
  parameter int DW      = 4,
  parameter int OPW     = 3,
  parameter int TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         rst,
  alu_arbiter_if.slave bus
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state, state_n;
  logic [IW-1:0]   idx, idx_n;
  logic [IW-1:0]   last, last_n;
  logic [IW-1:0]   win;
  logic            found;
  logic [CW-1:0]   cnt, cnt_n;
  logic [NREQ-1:0] gnt_q, gnt_n;
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_n;
  logic [DW-1:0]   rsp_result_q, rsp_result_n;
  logic            rsp_err_q, rsp_err_n;
  logic            alu_start_q, alu_start_n;
  logic [DW-1:0]   alu_a_q, alu_a_n;
  logic [DW-1:0]   alu_b_q, alu_b_n;
  logic [OPW-1:0]  alu_opcode_q, alu_opcode_n;

  // Circular search for the first active request starting just after last.
  always_comb begin
    win   = last;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      int cand;
      cand = int'(last) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!found && bus.req[IW'(cand)]) begin
        found = 1'b1;
        win   = IW'(cand);
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n      = state;
    idx_n        = idx;
    last_n       = last;
    cnt_n        = cnt;
    gnt_n        = '0;
    rsp_valid_n  = '0;
    alu_start_n  = 1'b0;
    rsp_result_n = rsp_result_q;
    rsp_err_n    = rsp_err_q;
    alu_a_n      = alu_a_q;
    alu_b_n      = alu_b_q;
    alu_opcode_n = alu_opcode_q;
    case (state)
      IDLE: begin
        if (found) begin
          idx_n        = win;
          alu_a_n      = bus.req_a[win*DW +: DW];
          alu_b_n      = bus.req_b[win*DW +: DW];
          alu_opcode_n = bus.req_op[win*OPW +: OPW];
          gnt_n        = NREQ'(1) << win;
          alu_start_n  = 1'b1;
          state_n      = ISSUE;
        end
      end
      ISSUE: begin
        cnt_n   = '0;
        state_n = WAIT;
      end
      WAIT: begin
        cnt_n = cnt + CW'(1);
        // done has priority over a timeout in the same cycle
        if (bus.alu_done) begin
          rsp_result_n = bus.alu_result;
          rsp_err_n    = 1'b0;
          rsp_valid_n  = NREQ'(1) << idx;
          state_n      = RESP;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          rsp_result_n = '0;
          rsp_err_n    = 1'b1;
          rsp_valid_n  = NREQ'(1) << idx;
          state_n      = RESP;
        end
      end
      RESP: begin
        last_n  = idx;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State, pointer, counter and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= '0;
      last         <= IW'(NREQ - 1);
      cnt          <= '0;
      gnt_q        <= '0;
      rsp_valid_q  <= '0;
      rsp_result_q <= '0;
      rsp_err_q    <= 1'b0;
      alu_start_q  <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_opcode_q <= '0;
    end else begin
      state        <= state_n;
      idx          <= idx_n;
      last         <= last_n;
      cnt          <= cnt_n;
      gnt_q        <= gnt_n;
      rsp_valid_q  <= rsp_valid_n;
      rsp_result_q <= rsp_result_n;
      rsp_err_q    <= rsp_err_n;
      alu_start_q  <= alu_start_n;
      alu_a_q      <= alu_a_n;
      alu_b_q      <= alu_b_n;
      alu_opcode_q <= alu_opcode_n;
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.alu_start  = alu_start_q;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_opcode = alu_opcode_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with a simple ALU engine model.
module tb_alu_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  logic       eng_en;
  logic       eng_done;
  logic [3:0] eng_res;
  int         eng_cnt;
  logic       man_done;
  logic [3:0] man_res;

  alu_arbiter_if #(.NREQ(4), .DW(4), .OPW(3)) bus ();

  alu_arbiter #(.NREQ(4), .DW(4), .OPW(3), .TIMEOUT(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign bus.alu_done   = eng_done | man_done;
  assign bus.alu_result = man_done ? man_res : eng_res;

  function automatic logic [3:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                       input logic [2:0] op);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      default: return 4'h0;
    endcase
  endfunction

  // Engine: done pulse 3 cycles after the start cycle, cleared by the shared reset.
  always @(negedge clk) begin
    if (rst) begin
      eng_cnt  = 0;
      eng_done = 1'b0;
    end else begin
      eng_done = 1'b0;
      if (eng_cnt > 0) begin
        eng_cnt = eng_cnt - 1;
        if (eng_cnt == 0) eng_done = 1'b1;
      end
      if (bus.alu_start && eng_en) begin
        eng_cnt = 3;
        eng_res = alu_f(bus.alu_a, bus.alu_b, bus.alu_opcode);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ops(input int i, input logic [3:0] a, input logic [3:0] b,
                         input logic [2:0] op);
    bus.req_a[i*4 +: 4]  = a;
    bus.req_b[i*4 +: 4]  = b;
    bus.req_op[i*3 +: 3] = op;
  endtask

  task automatic wait_gnt(output logic [3:0] g, output int cyc);
    g   = '0;
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cyc++;
      if (bus.gnt != 0) begin
        g = bus.gnt;
        break;
      end
    end
  endtask

  task automatic wait_rsp(output logic [3:0] r, output int cyc);
    r   = '0;
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cyc++;
      if (bus.rsp_valid != 0) begin
        r = bus.rsp_valid;
        break;
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"},   32'(bus.gnt), 0);
    chk({tag, "_rspv"},  32'(bus.rsp_valid), 0);
    chk({tag, "_res"},   32'(bus.rsp_result), 0);
    chk({tag, "_err"},   32'(bus.rsp_err), 0);
    chk({tag, "_start"}, 32'(bus.alu_start), 0);
    chk({tag, "_a"},     32'(bus.alu_a), 0);
    chk({tag, "_b"},     32'(bus.alu_b), 0);
    chk({tag, "_op"},    32'(bus.alu_opcode), 0);
  endtask

  logic [3:0] g, r;
  int         c;
  logic [3:0] exp2 [4];

  initial begin
    rst        = 1'b1;
    eng_en     = 1'b1;
    eng_done   = 1'b0;
    eng_res    = '0;
    eng_cnt    = 0;
    man_done   = 1'b0;
    man_res    = '0;
    bus.req    = '0;
    bus.req_a  = '0;
    bus.req_b  = '0;
    bus.req_op = '0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // single request: 3 + 5
    set_ops(0, 4'd3, 4'd5, 3'd0);
    bus.req = 4'b0001;
    wait_gnt(g, c);
    chk("t1_gnt", 32'(g), 32'h1);
    chk("t1_gnt_lat", 32'(c), 1);
    chk("t1_start", 32'(bus.alu_start), 1);
    chk("t1_a", 32'(bus.alu_a), 3);
    chk("t1_b", 32'(bus.alu_b), 5);
    chk("t1_op", 32'(bus.alu_opcode), 0);
    bus.req = 4'b0000;
    wait_rsp(r, c);
    chk("t1_rspv", 32'(r), 32'h1);
    chk("t1_rsp_lat", 32'(c), 4);
    chk("t1_gnt_at_rsp", 32'(bus.gnt), 0);
    chk("t1_res", 32'(bus.rsp_result), 8);
    chk("t1_err", 32'(bus.rsp_err), 0);
    @(negedge clk);
    chk("t1_rspv_clr", 32'(bus.rsp_valid), 0);
    chk("t1_res_hold", 32'(bus.rsp_result), 8);

    // all four after reset: order 0,1,2,3
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    set_ops(0, 4'h1, 4'h2, 3'd0);
    set_ops(1, 4'h2, 4'h5, 3'd1);
    set_ops(2, 4'hC, 4'hA, 3'd2);
    set_ops(3, 4'hC, 4'hA, 3'd3);
    exp2[0] = 4'h3;
    exp2[1] = 4'hD;
    exp2[2] = 4'h8;
    exp2[3] = 4'hE;
    bus.req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      wait_gnt(g, c);
      chk("t2_gnt", 32'(g), 32'(1) << k);
      if (k > 0) chk("t2_gnt_gap", 32'(c), 2);
      bus.req = bus.req & ~g;
      wait_rsp(r, c);
      chk("t2_rspv", 32'(r), 32'(1) << k);
      chk("t2_res", 32'(bus.rsp_result), 32'(exp2[k]));
      chk("t2_err", 32'(bus.rsp_err), 0);
    end

    // req0 and req2 held: alternate 0,2
    set_ops(0, 4'h7, 4'h1, 3'd0);
    set_ops(2, 4'h2, 4'h2, 3'd0);
    bus.req = 4'b0101;
    for (int k = 0; k < 8; k++) begin
      wait_gnt(g, c);
      chk("t3_gnt", 32'(g), (k % 2 == 0) ? 32'h1 : 32'h4);
      wait_rsp(r, c);
      chk("t3_rspv", 32'(r), (k % 2 == 0) ? 32'h1 : 32'h4);
    end
    bus.req = 4'b0000;
    @(negedge clk);
    chk("t3_no_extra", 32'(bus.gnt), 0);
    chk("t3_last_res", 32'(bus.rsp_result), 4);

    // timeout: engine silent
    eng_en = 1'b0;
    set_ops(1, 4'h6, 4'h6, 3'd1);
    bus.req = 4'b0010;
    wait_gnt(g, c);
    chk("t4_gnt", 32'(g), 32'h2);
    bus.req = 4'b0000;
    wait_rsp(r, c);
    chk("t4_rspv", 32'(r), 32'h2);
    chk("t4_lat", 32'(c), 16);
    chk("t4_err", 32'(bus.rsp_err), 1);
    chk("t4_res", 32'(bus.rsp_result), 0);
    eng_en = 1'b1;
    set_ops(3, 4'h9, 4'h3, 3'd0);
    bus.req = 4'b1000;
    wait_gnt(g, c);
    chk("t4b_gnt", 32'(g), 32'h8);
    bus.req = 4'b0000;
    wait_rsp(r, c);
    chk("t4b_rspv", 32'(r), 32'h8);
    chk("t4b_lat", 32'(c), 4);
    chk("t4b_err", 32'(bus.rsp_err), 0);
    chk("t4b_res", 32'(bus.rsp_result), 32'hC);

    // stray done in IDLE
    man_res  = 4'h5;
    man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t5_stray_rspv", 32'(bus.rsp_valid), 0);
      chk("t5_stray_gnt", 32'(bus.gnt), 0);
    end

    // done on the final timeout cycle wins
    eng_en = 1'b0;
    set_ops(0, 4'h1, 4'h1, 3'd0);
    bus.req = 4'b0001;
    wait_gnt(g, c);
    chk("t5_gnt", 32'(g), 32'h1);
    bus.req = 4'b0000;
    repeat (15) @(negedge clk);
    chk("t5_pre_rspv", 32'(bus.rsp_valid), 0);
    man_res  = 4'h6;
    man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    chk("t5_rspv", 32'(bus.rsp_valid), 32'h1);
    chk("t5_err", 32'(bus.rsp_err), 0);
    chk("t5_res", 32'(bus.rsp_result), 6);
    eng_en = 1'b1;

    // reset during WAIT of req2
    set_ops(2, 4'hA, 4'h5, 3'd4);
    bus.req = 4'b0100;
    wait_gnt(g, c);
    chk("t6_gnt", 32'(g), 32'h4);
    bus.req = 4'b0000;
    @(negedge clk);
    chk("t6_a_before", 32'(bus.alu_a), 32'hA);
    rst = 1'b1;
    #1;
    chk_all_zero("t6_rst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("t6_no_rsp", 32'(bus.rsp_valid), 0);
    end
    set_ops(1, 4'h1, 4'h1, 3'd0);
    set_ops(3, 4'h2, 4'h2, 3'd0);
    bus.req = 4'b1010;
    wait_gnt(g, c);
    chk("t6_first_gnt", 32'(g), 32'h2);
    bus.req = 4'b1000;
    wait_rsp(r, c);
    chk("t6_rspv", 32'(r), 32'h2);
    bus.req = 4'b0000;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
